// File: rtl/xor_ram_scanner_pkg.sv
// Shared types and helpers for the XOR toggle RAM scanner.
// Holds the FSM state encoding and the address-width helper.
package xor_ram_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to address entries 0..depth-1; at least 1 so DEPTH=2 still works.
    function automatic int addr_bits(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/xor_ram_scanner.sv
// Port-B sweep engine for a 1-bit XOR toggle RAM: reports the address of every set bit
// on a valid/ready stream and optionally clears it by toggling.
module xor_ram_scanner
    import xor_ram_scanner_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = addr_bits(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear_en,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    input  logic                  ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [ADDR_WIDTH:0]   found_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
    logic                  clear_q_reg, clear_q_next;
    logic [ADDR_WIDTH:0]   found_count_reg, found_count_next;
    logic                  out_valid_reg, out_valid_next;
    logic [ADDR_WIDTH-1:0] out_addr_reg, out_addr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= '0;
            clear_q_reg     <= 1'b0;
            found_count_reg <= '0;
            out_valid_reg   <= 1'b0;
            out_addr_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            clear_q_reg     <= clear_q_next;
            found_count_reg <= found_count_next;
            out_valid_reg   <= out_valid_next;
            out_addr_reg    <= out_addr_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        clear_q_next     = clear_q_reg;
        found_count_next = found_count_reg;
        out_valid_next   = out_valid_reg;
        out_addr_next    = out_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next       = ST_SCAN;
                    ptr_next         = '0;
                    found_count_next = '0;
                    clear_q_next     = clear_en;
                end
            end
            ST_SCAN: begin
                if (ram_q) begin
                    state_next     = ST_HOLD;
                    out_valid_next = 1'b1;
                    out_addr_next  = ptr_reg;
                end else if (ptr_reg == LAST_ADDR) begin
                    state_next = ST_DONE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_valid_reg && out_ready) begin
                    found_count_next = found_count_reg + 1'b1;
                    out_valid_next   = 1'b0;
                    if (ptr_reg == LAST_ADDR) begin
                        state_next = ST_DONE;
                        ptr_next   = '0;
                    end else begin
                        state_next = ST_SCAN;
                        ptr_next   = ptr_reg + 1'b1;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Abort freezes counters where they are so found_count keeps its partial value.
        if (abort && state_reg != ST_IDLE) begin
            state_next       = ST_IDLE;
            ptr_next         = ptr_reg;
            clear_q_next     = clear_q_reg;
            found_count_next = found_count_reg;
            out_valid_next   = 1'b0;
            out_addr_next    = out_addr_reg;
        end
    end

    // Toggle only while the bit still reads 1, so a bit already cleared by port A is not re-set.
    assign ram_wr      = (state_reg == ST_HOLD) & out_ready & clear_q_reg & ram_q & ~abort & ~rst;
    assign ram_addr    = ptr_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign out_valid   = out_valid_reg;
    assign out_addr    = out_addr_reg;
    assign found_count = found_count_reg;

endmodule
